// File: rtl/clock_defs.sv
// Clock-management constants shared between the reference generators and the
// register map that programs their dividers.
package clock_defs;

  localparam int REF_DIV_MIN     = 2;
  localparam int REF_WIDTH       = 16;
  localparam int REF_DEFAULT_DIV = 25;

endpackage

// File: rtl/ref_out_gen.sv
// Divides clk by a programmable integer into a near-50% reference output, with
// an edge strobe and a period counter; divider changes land on period boundaries.
module ref_out_gen
  import clock_defs::*;
#(
  parameter int WIDTH       = REF_WIDTH,
  parameter int DEFAULT_DIV = REF_DEFAULT_DIV,
  parameter int CNT_WIDTH   = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 en,
  input  logic                 sync,
  input  logic [WIDTH-1:0]     div_in,
  input  logic                 div_wr,
  output logic                 div_pending,
  output logic                 ref_out,
  output logic                 ref_edge,
  output logic [CNT_WIDTH-1:0] period_count
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HIGH = 2'd1,
    LOW  = 2'd2
  } ref_state_e;

  function automatic logic [WIDTH-1:0] clamp_div(input logic [WIDTH-1:0] d);
    return (d < WIDTH'(REF_DIV_MIN)) ? WIDTH'(REF_DIV_MIN) : d;
  endfunction

  ref_state_e       state;
  logic [WIDTH-1:0] cnt;
  logic [WIDTH-1:0] div_active;
  logic [WIDTH-1:0] div_shadow;
  logic [WIDTH-1:0] wr_div;
  logic [WIDTH-1:0] next_div;
  logic [WIDTH-1:0] start_cnt;
  logic [WIDTH-1:0] low_cnt;
  logic             start;
  logic             stop;

  // A write coinciding with a period start is used directly, bypassing the shadow.
  assign wr_div    = clamp_div(div_in);
  assign next_div  = div_wr ? wr_div : (div_pending ? div_shadow : div_active);
  assign start_cnt = (next_div - (next_div >> 1)) - WIDTH'(1);
  assign low_cnt   = (div_active >> 1) - WIDTH'(1);

  // Boundary decode: sync overrides the FSM, so a sync on a natural boundary
  // still produces a single period start.
  always_comb begin
    start = 1'b0;
    stop  = 1'b0;
    if (sync) begin
      start = en;
      stop  = !en;
    end else begin
      case (state)
        IDLE: start = en;
        LOW: begin
          if (cnt == '0) begin
            start = en;
            stop  = !en;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      cnt          <= '0;
      ref_out      <= 1'b0;
      ref_edge     <= 1'b0;
      div_pending  <= 1'b0;
      period_count <= '0;
      div_active   <= WIDTH'(DEFAULT_DIV);
      div_shadow   <= WIDTH'(DEFAULT_DIV);
    end else begin
      ref_edge <= start;
      if (div_wr) begin
        div_shadow <= wr_div;
      end
      if (start) begin
        div_pending <= 1'b0;
      end else if (div_wr) begin
        div_pending <= 1'b1;
      end

      if (start) begin
        state        <= HIGH;
        ref_out      <= 1'b1;
        cnt          <= start_cnt;
        div_active   <= next_div;
        period_count <= period_count + CNT_WIDTH'(1);
      end else if (stop) begin
        state   <= IDLE;
        ref_out <= 1'b0;
        cnt     <= '0;
      end else begin
        case (state)
          HIGH: begin
            if (cnt == '0) begin
              state   <= LOW;
              ref_out <= 1'b0;
              cnt     <= low_cnt;
            end else begin
              cnt <= cnt - WIDTH'(1);
            end
          end
          LOW:     cnt <= cnt - WIDTH'(1);
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_ref_out_gen.sv
// Randomised and directed bench for ref_out_gen against a position-in-period
// model of the reference output.
module tb_ref_out_gen;

  localparam int W    = 16;
  localparam int CW   = 6;
  localparam int DEFD = 25;

  logic          clk;
  logic          rst;
  logic          en;
  logic          sync;
  logic [W-1:0]  div_in;
  logic          div_wr;
  logic          div_pending;
  logic          ref_out;
  logic          ref_edge;
  logic [CW-1:0] period_count;

  int checks = 0;
  int errors = 0;

  ref_out_gen #(.WIDTH(W), .DEFAULT_DIV(DEFD), .CNT_WIDTH(CW)) dut (
    .clk(clk), .rst(rst), .en(en), .sync(sync), .div_in(div_in), .div_wr(div_wr),
    .div_pending(div_pending), .ref_out(ref_out), .ref_edge(ref_edge),
    .period_count(period_count)
  );

  initial clk = 1'b0;
  always #2 clk = ~clk;

  // Model: a running period is a position 0..div-1; output is high for the
  // first div - div/2 positions.
  bit modelValid = 0;
  int mDiv, mShadow, mPending, mCount, mRunning, mPos, mRef, mEdge;

  function automatic int clampI(input int d);
    return (d < 2) ? 2 : d;
  endfunction

  always @(posedge clk) begin
    int doStart, doStop, d;
    if (rst) begin
      modelValid = 1;
      mDiv = DEFD; mShadow = DEFD; mPending = 0; mCount = 0;
      mRunning = 0; mPos = 0; mRef = 0; mEdge = 0;
    end else if (modelValid) begin
      doStart = 0; doStop = 0;
      if (sync) begin
        doStart = en; doStop = !en;
      end else if (!mRunning) begin
        doStart = en;
      end else if (mPos == mDiv - 1) begin
        doStart = en; doStop = !en;
      end else begin
        mPos = mPos + 1;
      end
      if (doStart) begin
        d = div_wr ? clampI(int'(div_in)) : (mPending ? mShadow : mDiv);
        mDiv = d;
        if (div_wr) mShadow = d;
        mPending = 0;
        mRunning = 1;
        mPos = 0;
        mCount = (mCount + 1) % (1 << CW);
        mEdge = 1;
      end else begin
        mEdge = 0;
        if (div_wr) begin
          mShadow = clampI(int'(div_in));
          mPending = 1;
        end
        if (doStop) mRunning = 0;
      end
      mRef = (mRunning && mPos < mDiv - mDiv / 2) ? 1 : 0;
    end
  end

  task automatic checkOutput(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (modelValid && !rst) begin
      checkOutput("model_ref_out", int'(ref_out), mRef);
      checkOutput("model_ref_edge", int'(ref_edge), mEdge);
      checkOutput("model_div_pending", int'(div_pending), mPending);
      checkOutput("model_period_count", int'(period_count), mCount);
    end
  end

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic applyStimulus(input bit e, input bit s, input bit w, input int din);
    en = e;
    sync = s;
    div_wr = w;
    div_in = W'(din);
  endtask

  task automatic measureRun(input bit value, input int maxC, output int len);
    len = 0;
    while (ref_out == value && len < maxC) begin
      len++;
      step(1);
    end
  endtask

  task automatic waitEdge(input int maxC, output int n);
    n = 0;
    do begin
      step(1);
      n++;
    end while (!ref_edge && n < maxC);
  endtask

  task automatic writeDiv(input int din);
    applyStimulus(en, 0, 1, din);
    step(1);
    applyStimulus(en, 0, 0, 0);
  endtask

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int len, n, prev, found, prevAtWrap;
    rst = 1'b1;
    applyStimulus(0, 0, 0, 0);
    step(2);
    rst = 1'b0;
    checkOutput("reset_ref_out", int'(ref_out), 0);
    checkOutput("reset_count", int'(period_count), 0);
    checkOutput("reset_pending", int'(div_pending), 0);

    // Default divider: 13 high / 12 low
    applyStimulus(1, 0, 0, 0);
    step(1);
    checkOutput("t1_rise", int'(ref_out), 1);
    checkOutput("t1_edge", int'(ref_edge), 1);
    measureRun(1, 40, len); checkOutput("t1_high", len, 13);
    measureRun(0, 40, len); checkOutput("t1_low", len, 12);
    step(50);
    checkOutput("t1_count4", int'(period_count), 4);
    checkOutput("t1_edge4", int'(ref_edge), 1);

    // Write 10 in cycle 5; current period keeps 25
    step(4);
    writeDiv(10);
    checkOutput("t2_pending", int'(div_pending), 1);
    waitEdge(40, n);
    checkOutput("t2_old_len", 5 + n, 25);
    checkOutput("t2_pending_clr", int'(div_pending), 0);
    measureRun(1, 40, len); checkOutput("t2_high", len, 5);
    measureRun(0, 40, len); checkOutput("t2_low", len, 5);

    // Two writes in one period: last wins
    step(1);
    writeDiv(8);
    writeDiv(6);
    waitEdge(40, n);
    measureRun(1, 40, len); checkOutput("t3_w6_high", len, 3);
    measureRun(0, 40, len); checkOutput("t3_w6_low", len, 3);

    writeDiv(0);
    waitEdge(40, n);
    measureRun(1, 40, len); checkOutput("t3_d0_high", len, 1);
    measureRun(0, 40, len); checkOutput("t3_d0_low", len, 1);
    writeDiv(1);
    waitEdge(40, n);
    measureRun(1, 40, len); checkOutput("t3_d1_high", len, 1);
    measureRun(0, 40, len); checkOutput("t3_d1_low", len, 1);
    writeDiv(3);
    waitEdge(40, n);
    measureRun(1, 40, len); checkOutput("t3_d3_high", len, 2);
    measureRun(0, 40, len); checkOutput("t3_d3_low", len, 1);

    // Enable dropped in cycle 3 of HIGH: no truncation
    writeDiv(25);
    waitEdge(40, n);
    step(2);
    applyStimulus(0, 0, 0, 0);
    step(1);
    measureRun(1, 40, len); checkOutput("t4_high_full", 3 + len, 13);
    step(32);
    checkOutput("t4_idle_ref", int'(ref_out), 0);
    checkOutput("t4_idle_edge", int'(ref_edge), 0);
    applyStimulus(1, 0, 0, 0);
    step(1);
    checkOutput("t4_restart", int'(ref_out), 1);

    // Sync mid-LOW with en=1, then mid-HIGH with en=0
    step(18);
    applyStimulus(1, 1, 0, 0);
    step(1);
    applyStimulus(1, 0, 0, 0);
    checkOutput("t5_sync_ref", int'(ref_out), 1);
    checkOutput("t5_sync_edge", int'(ref_edge), 1);
    measureRun(1, 40, len); checkOutput("t5_sync_high", len, 13);
    waitEdge(40, n);
    step(3);
    applyStimulus(0, 1, 0, 0);
    step(1);
    applyStimulus(0, 0, 0, 0);
    checkOutput("t5_trunc", int'(ref_out), 0);
    step(20);
    checkOutput("t5_idle", int'(ref_out), 0);

    // Reset mid-HIGH with a pending divider
    applyStimulus(1, 0, 0, 0);
    step(4);
    writeDiv(7);
    checkOutput("t6_pending", int'(div_pending), 1);
    rst = 1'b1;
    step(1);
    rst = 1'b0;
    checkOutput("t6_ref", int'(ref_out), 0);
    checkOutput("t6_pending_clr", int'(div_pending), 0);
    checkOutput("t6_count", int'(period_count), 0);
    step(1);
    measureRun(1, 40, len); checkOutput("t6_high", len, 13);
    measureRun(0, 40, len); checkOutput("t6_low", len, 12);

    // Counter wrap at 2^CW
    writeDiv(2);
    found = 0; prevAtWrap = -1;
    for (int i = 0; i < 400 && !found; i++) begin
      prev = int'(period_count);
      step(1);
      if (ref_edge && period_count == 0) begin
        found = 1;
        prevAtWrap = prev;
      end
    end
    checkOutput("wrap_seen", found, 1);
    checkOutput("wrap_prev", prevAtWrap, (1 << CW) - 1);

    // Randomised traffic
    for (int i = 0; i < 3000; i++) begin
      applyStimulus($urandom_range(0, 9) != 0, $urandom_range(0, 49) == 0,
                    $urandom_range(0, 19) == 0, $urandom_range(0, 12));
      rst = ($urandom_range(0, 999) == 0);
      step(1);
    end
    rst = 1'b0;
    applyStimulus(1, 0, 0, 0);
    step(10);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
